uart_dma_tx_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the UART DMA send stream between `N_REQ` on-chip requesters. Each requester supplies a payload byte stream and a length. The arbiter wraps each payload in the link frame format and drives the DMA send port:

- byte 0: sync `0x55`
- byte 1: channel id
- byte 2: payload length
- bytes 3..: payload

It sits between the capture/control sources and the UART DMA block's `tdata/tlast/tvalid/tready` input. It guarantees whole frames are never interleaved.

---
 rtl/uart_dma_tx_arbiter_pkg.sv | 36 +++
 rtl/uart_dma_tx_arbiter_rr_pick.sv | 39 +++
 rtl/uart_dma_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_dma_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dma_tx_arbiter_pkg.sv
// uart_arb_pkg: shared constants and state encoding for the UART DMA
// transmit arbiter.
//   SYNC_BYTE : first byte of every link frame
//   HDR_LEN   : number of header bytes (sync, channel id, length)
//   PAD_BYTE  : filler emitted when a requester ends its payload early
//   IDX_W     : width of a requester index (up to 8 requesters)
//   arb_state_e : frame sequencer states
package uart_arb_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'h55;
    localparam int unsigned HDR_LEN   = 3;
    localparam logic [7:0]  PAD_BYTE  = 8'h00;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CHID,
        LEN,
        PAYLOAD,
        PAD,
        DRAIN
    } arb_state_e;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      n);
        return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 3'd1;
    endfunction

    // Total bytes on the DMA port for a payload of len bytes (0 = no frame).
    function automatic int unsigned frame_bytes(input logic [7:0] len);
        return (len == 8'd0) ? 0 : 32'(len) + HDR_LEN;
    endfunction

endpackage

// File: rtl/uart_dma_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index to start searching from (owned by the parent)
//   o_grant : one-hot grant of the first requester at/after i_ptr (wrapping)
//   o_idx   : binary index of the granted requester
//   o_valid : at least one request is present
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic found;

    // Offset i is tried in order; inner loop maps (ptr + i) mod N onto a
    // constant bit position so no variable-width bit select is needed.
    always_comb begin
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!found && (j == ((32'(i_ptr) + i) % N_REQ)) && i_req[j]) begin
                    found      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/uart_dma_tx_arbiter.sv
// uart_dma_tx_arbiter: frame-level round-robin arbiter in front of the UART
// DMA send port. Each granted requester's payload is wrapped as
//   0x55, CH_BASE+k, len, payload[len]
// and whole frames are never interleaved.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req_tdata/tvalid/tlast/len : per-requester payload stream and length
//   o_req_tready          : per-requester payload accept
//   o_uart_DMA_tdata/tlast/tvalid, i_uart_DMA_tready : DMA send port
//   o_grant               : one-hot current frame owner
//   o_busy                : a frame is in progress
//   o_err, o_err_id       : length/tlast mismatch pulse and offending index
module uart_dma_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter logic [7:0]  CH_BASE = 8'h10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [8*N_REQ-1:0]   i_req_tdata,
    input  logic [N_REQ-1:0]     i_req_tvalid,
    input  logic [N_REQ-1:0]     i_req_tlast,
    input  logic [8*N_REQ-1:0]   i_req_len,
    output logic [N_REQ-1:0]     o_req_tready,
    output logic [7:0]           o_uart_DMA_tdata,
    output logic                 o_uart_DMA_tlast,
    output logic                 o_uart_DMA_tvalid,
    input  logic                 i_uart_DMA_tready,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_err,
    output logic [2:0]           o_err_id
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             drain_pend_q, drain_pend_d;
    logic             err_q, err_d;
    logic [2:0]       err_id_q, err_id_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [7:0]       pick_len;

    logic [7:0]       cur_data;
    logic             cur_valid;
    logic             cur_last;
    logic [7:0]       chan_id;

    logic             slot_free;
    logic             xfer;
    logic             own_ready;
    logic             accept;
    logic             release_frame;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .i_req  (i_req_tvalid),
        .i_ptr  (ptr_q),
        .o_grant(pick_grant),
        .o_idx  (pick_idx),
        .o_valid(pick_valid)
    );

    assign xfer      = tvalid_q && i_uart_DMA_tready;
    assign slot_free = !tvalid_q || i_uart_DMA_tready;
    assign accept    = own_ready && cur_valid;
    assign chan_id   = CH_BASE + {5'd0, idx_q};

    // Per-requester mux: stream of the current owner, length of the candidate.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        pick_len  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == idx_q) begin
                cur_data  = i_req_tdata[8*k +: 8];
                cur_valid = i_req_tvalid[k];
                cur_last  = i_req_tlast[k];
            end
            if (IDX_W'(k) == pick_idx) begin
                pick_len = i_req_len[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            drain_pend_q <= 1'b0;
            err_q        <= 1'b0;
            err_id_q     <= '0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            drain_pend_q <= drain_pend_d;
            err_q        <= err_d;
            err_id_q     <= err_id_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
        end
    end

    // Next-state and datapath. LEN marks "header sent, no payload loaded
    // yet"; payload is already accepted there so the first payload byte
    // loads while the length byte leaves, avoiding a bubble.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        drain_pend_d  = drain_pend_q;
        err_d         = 1'b0;
        err_id_d      = err_id_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        release_frame = 1'b0;

        if (xfer) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    grant_d = pick_grant;
                    cnt_d   = pick_len;
                    if (pick_len == 8'd0) begin
                        state_d  = DRAIN;
                        err_d    = 1'b1;
                        err_id_d = pick_idx;
                    end else begin
                        tdata_d  = SYNC_BYTE;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b1;
                        state_d  = SYNC;
                    end
                end
            end
            SYNC: begin
                if (xfer) begin
                    tdata_d  = chan_id;
                    tvalid_d = 1'b1;
                    state_d  = CHID;
                end
            end
            CHID: begin
                if (xfer) begin
                    tdata_d  = cnt_q;
                    tvalid_d = 1'b1;
                    state_d  = LEN;
                end
            end
            LEN, PAYLOAD: begin
                if (cnt_q != 8'd0) begin
                    if (accept) begin
                        tdata_d  = cur_data;
                        tvalid_d = 1'b1;
                        tlast_d  = (cnt_q == 8'd1);
                        cnt_d    = cnt_q - 8'd1;
                        state_d  = PAYLOAD;
                        if ((cnt_q == 8'd1) && !cur_last) begin
                            // Late tlast: close the frame, then discard the rest.
                            err_d        = 1'b1;
                            err_id_d     = idx_q;
                            drain_pend_d = 1'b1;
                        end else if ((cnt_q != 8'd1) && cur_last) begin
                            // Early tlast: pad out to the advertised length.
                            err_d    = 1'b1;
                            err_id_d = idx_q;
                            state_d  = PAD;
                        end
                    end
                end else if (xfer) begin
                    if (drain_pend_q) begin
                        drain_pend_d = 1'b0;
                        state_d      = DRAIN;
                    end else begin
                        release_frame = 1'b1;
                    end
                end
            end
            PAD: begin
                if (cnt_q != 8'd0) begin
                    if (slot_free) begin
                        tdata_d  = PAD_BYTE;
                        tvalid_d = 1'b1;
                        tlast_d  = (cnt_q == 8'd1);
                        cnt_d    = cnt_q - 8'd1;
                    end
                end else if (xfer) begin
                    release_frame = 1'b1;
                end
            end
            DRAIN: begin
                if (accept && cur_last) begin
                    release_frame = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_frame) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = next_ptr(idx_q, N_REQ);
        end
    end

    // Outputs.
    always_comb begin
        own_ready = 1'b0;
        case (state_q)
            LEN, PAYLOAD: own_ready = slot_free && (cnt_q != 8'd0);
            DRAIN:        own_ready = 1'b1;
            default:      own_ready = 1'b0;
        endcase

        o_req_tready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            o_req_tready[k] = own_ready && (IDX_W'(k) == idx_q);
        end

        o_uart_DMA_tdata  = tdata_q;
        o_uart_DMA_tlast  = tlast_q;
        o_uart_DMA_tvalid = tvalid_q;
        o_grant           = grant_q;
        o_busy            = (state_q != IDLE);
        o_err             = err_q;
        o_err_id          = err_id_q;
    end

endmodule

// File: tb/tb_uart_dma_tx_arbiter.sv
module tb_uart_dma_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*N-1:0] req_tdata;
    logic [N-1:0]   req_tvalid;
    logic [N-1:0]   req_tlast;
    logic [8*N-1:0] req_len = '0;
    logic [N-1:0]   req_tready;
    logic [7:0]     dma_tdata;
    logic           dma_tlast;
    logic           dma_tvalid;
    logic           dma_tready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err;
    logic [2:0]     err_id;

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [N][$];
    logic [8:0] out_q [$];
    logic [8:0] exp_q [$];
    logic [N-1:0] acc_s = '0;
    int   err_cnt   = 0;
    int   bp_viol   = 0;
    int   hold_viol = 0;
    bit   bp_mode   = 1'b0;
    int   bp_cnt    = 0;
    logic [3:0] bp_pat = 4'b1001;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    uart_dma_tx_arbiter #(
        .N_REQ  (N),
        .CH_BASE(8'h10)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_tdata      (req_tdata),
        .i_req_tvalid     (req_tvalid),
        .i_req_tlast      (req_tlast),
        .i_req_len        (req_len),
        .o_req_tready     (req_tready),
        .o_uart_DMA_tdata (dma_tdata),
        .o_uart_DMA_tlast (dma_tlast),
        .o_uart_DMA_tvalid(dma_tvalid),
        .i_uart_DMA_tready(dma_tready),
        .o_grant          (grant),
        .o_busy           (busy),
        .o_err            (err),
        .o_err_id         (err_id)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Requester sources and DMA ready pattern, driven just after the edge.
    initial begin
        req_tdata  = '0;
        req_tvalid = '0;
        req_tlast  = '0;
        dma_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc_s[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    req_tvalid[k]       = 1'b1;
                    req_tdata[8*k +: 8] = src_q[k][0][7:0];
                    req_tlast[k]        = src_q[k][0][8];
                end else begin
                    req_tvalid[k]       = 1'b0;
                    req_tdata[8*k +: 8] = 8'h00;
                    req_tlast[k]        = 1'b0;
                end
            end
            dma_tready = bp_mode ? bp_pat[bp_cnt % 4] : 1'b1;
            bp_cnt++;
        end
    end

    // Monitor: handshakes seen here complete at the following rising edge.
    initial forever begin
        @(negedge clk);
        acc_s = req_tvalid & req_tready;
        if (dma_tvalid && dma_tready) out_q.push_back({dma_tlast, dma_tdata});
        if (err) err_cnt++;
        if (bp_mode && dma_tvalid && !dma_tready && (req_tready != '0)) bp_viol++;
        if (prev_stall && ({dma_tvalid, dma_tlast, dma_tdata} != prev_out)) hold_viol++;
        prev_stall = dma_tvalid && !dma_tready;
        prev_out   = {dma_tvalid, dma_tlast, dma_tdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int k, input int len);
        req_len[8*k +: 8] = 8'(len);
    endtask

    task automatic send(input int k, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            src_q[k].push_back({(i == n - 1), b});
        end
    endtask

    // Reference frame: header, then sent payload bytes, padded with 00.
    task automatic expect_frame(input int k, input int len, input logic [7:0] base, input int sent);
        if (len != 0) begin
            exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'h10 + 8'(k)});
            exp_q.push_back({1'b0, 8'(len)});
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                d = (i < sent) ? base + 8'(i) : 8'h00;
                exp_q.push_back({(i == len - 1), d});
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nbytes"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
        end
    endtask

    function automatic bit src_empty();
        bit e;
        e = (req_tvalid == '0);
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input string tag, input int n);
        int  cyc;
        bit  ok;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 2000 && !ok) begin
            @(posedge clk);
            #2;
            cyc++;
            ok = (out_q.size() >= n) && src_empty() && !busy;
        end
        chk({tag, "_done"}, 32'(ok), 1);
    endtask

    task automatic start_test();
        @(negedge clk);
        out_q.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(dma_tvalid), 0);
        chk({tag, "_tdata"},  32'(dma_tdata), 0);
        chk({tag, "_tlast"},  32'(dma_tlast), 0);
        chk({tag, "_grant"},  32'(grant), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_err"},    32'(err), 0);
        chk({tag, "_err_id"}, 32'(err_id), 0);
        chk({tag, "_rready"}, 32'(req_tready), 0);
    endtask

    initial begin
        int c;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single frame with first-byte latency
        start_test();
        set_len(0, 3);
        send(0, 3, 8'hA1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_grant",  32'(grant), 32'h1);
        chk("lat_tvalid", 32'(dma_tvalid), 1);
        chk("lat_tdata",  32'(dma_tdata), 32'h55);
        chk("lat_busy",   32'(busy), 1);
        wait_done("single", 6);
        expect_frame(0, 3, 8'hA1, 3);
        compare("single");
        chk("single_err", 32'(err_cnt), 0);

        // Round robin from reset, then pointer position 3 wins over 0
        do_reset();
        start_test();
        set_len(1, 2);
        set_len(2, 2);
        send(1, 2, 8'h31);
        send(2, 2, 8'h41);
        wait_done("rr12", 10);
        expect_frame(1, 2, 8'h31, 2);
        expect_frame(2, 2, 8'h41, 2);
        compare("rr12");
        start_test();
        set_len(0, 1);
        set_len(3, 1);
        send(0, 1, 8'h51);
        send(3, 1, 8'h61);
        wait_done("rr30", 8);
        expect_frame(3, 1, 8'h61, 1);
        expect_frame(0, 1, 8'h51, 1);
        compare("rr30");

        // Zero length on requester 3: drained, nothing emitted
        start_test();
        set_len(3, 0);
        send(3, 2, 8'hE1);
        wait_done("zero", 0);
        compare("zero");
        chk("zero_err",    32'(err_cnt), 1);
        chk("zero_err_id", 32'(err_id), 3);

        // Early tlast: padded with 00
        start_test();
        set_len(0, 4);
        send(0, 2, 8'hB1);
        wait_done("early", 7);
        expect_frame(0, 4, 8'hB1, 2);
        compare("early");
        chk("early_err",    32'(err_cnt), 1);
        chk("early_err_id", 32'(err_id), 0);

        // Late tlast: C3, C4 drained
        start_test();
        set_len(0, 2);
        send(0, 4, 8'hC1);
        wait_done("late", 5);
        expect_frame(0, 2, 8'hC1, 2);
        compare("late");
        chk("late_err", 32'(err_cnt), 1);

        // Backpressure 1,0,0,1,...
        start_test();
        bp_viol   = 0;
        hold_viol = 0;
        bp_mode   = 1'b1;
        set_len(0, 4);
        send(0, 4, 8'h01);
        wait_done("bp", 7);
        bp_mode = 1'b0;
        expect_frame(0, 4, 8'h01, 4);
        compare("bp");
        chk("bp_rready_stall", 32'(bp_viol), 0);
        chk("bp_hold",         32'(hold_viol), 0);
        chk("bp_err",          32'(err_cnt), 0);

        // Maximum length 255 -> 258-byte frame
        start_test();
        set_len(1, 255);
        send(1, 255, 8'h00);
        wait_done("len255", 258);
        expect_frame(1, 255, 8'h00, 255);
        compare("len255");
        chk("len255_err", 32'(err_cnt), 0);

        // Reset after the 2nd payload byte of a len=5 frame
        start_test();
        set_len(0, 5);
        send(0, 5, 8'h71);
        c = 0;
        while (out_q.size() < 5 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("mid_reach", 32'(out_q.size() >= 5), 1);
        rst = 1'b1;
        for (int k = 0; k < N; k++) src_q[k].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        start_test();
        set_len(0, 1);
        set_len(2, 1);
        send(0, 1, 8'h81);
        send(2, 1, 8'h91);
        wait_done("after_rst", 8);
        expect_frame(0, 1, 8'h81, 1);
        expect_frame(2, 1, 8'h91, 1);
        compare("after_rst");
        chk("after_rst_err", 32'(err_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
